// File: rtl/mem_read_arbiter_if.sv
// Requester ports and AXI read channels of mem_read_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              err;

    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;

    logic              RVALID;
    logic              RREADY;
    logic              RLAST;
    logic [1:0]        RRESP;
    logic [DATA_W-1:0] RDATA;

    modport master (
        input  if_req, if_addr, ls_req, ls_addr,
        input  ARREADY, RVALID, RLAST, RRESP, RDATA,
        output if_valid, if_rdata, ls_valid, ls_rdata, err,
        output ARVALID, ARADDR, ARPROT, RREADY
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_addr,
        output ARREADY, RVALID, RLAST, RRESP, RDATA,
        input  if_valid, if_rdata, ls_valid, ls_rdata, err,
        input  ARVALID, ARADDR, ARPROT, RREADY
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-requester (fetch / load) arbiter onto a single AXI read port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority with load winning.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    mem_read_arbiter_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state;
    logic              grant_ls;
    logic              dropped;
    logic              err_seen;
    logic [3:0]        beat_cnt;

    logic [ADDR_W-1:0] araddr_q;
    logic [2:0]        arprot_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              if_valid_q;
    logic              ls_valid_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic              pick_ls;
    logic              req_granted;
    logic              beat;
    logic              deliver;

`ifdef MEM_ARB_RR_EN
    logic              last_ls;

    // On a tie the requester that was not granted last time wins.
    always_comb begin
        pick_ls = bus.ls_req;
        if (bus.if_req && bus.ls_req) begin
            pick_ls = !last_ls;
        end
    end
`else
    assign pick_ls = bus.ls_req;
`endif

    assign req_granted = grant_ls ? bus.ls_req : bus.if_req;
    assign beat        = bus.RVALID && rready_q;
    // A requester that let go of req at any point during the transaction gets no response.
    assign deliver     = !dropped && req_granted;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state      <= IDLE;
            grant_ls   <= 1'b0;
            dropped    <= 1'b0;
            err_seen   <= 1'b0;
            beat_cnt   <= 4'd0;
            araddr_q   <= '0;
            arprot_q   <= 3'b000;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls    <= 1'b0;
`endif
        end else begin
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            err_q      <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.if_req || bus.ls_req) begin
                        grant_ls  <= pick_ls;
                        araddr_q  <= pick_ls ? bus.ls_addr : bus.if_addr;
                        arprot_q  <= pick_ls ? 3'b000 : 3'b100;
                        arvalid_q <= 1'b1;
                        dropped   <= 1'b0;
                        err_seen  <= 1'b0;
                        beat_cnt  <= 4'd0;
                        state     <= ADDR;
`ifdef MEM_ARB_RR_EN
                        last_ls   <= pick_ls;
`endif
                    end
                end

                ADDR: begin
                    if (!req_granted) begin
                        dropped <= 1'b1;
                    end
                    if (bus.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (!req_granted) begin
                        dropped <= 1'b1;
                    end
                    if (beat) begin
                        if (beat_cnt != 4'hF) begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                        if (bus.RRESP[1]) begin
                            err_seen <= 1'b1;
                        end
                        if (bus.RLAST) begin
                            rready_q <= 1'b0;
                            state    <= RESP;
                            if (deliver) begin
                                err_q <= err_seen || bus.RRESP[1];
                                if (grant_ls) begin
                                    ls_valid_q <= 1'b1;
                                    ls_rdata_q <= bus.RDATA;
                                end else begin
                                    if_valid_q <= 1'b1;
                                    if_rdata_q <= bus.RDATA;
                                end
                            end
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ARVALID  = arvalid_q;
    assign bus.ARADDR   = araddr_q;
    assign bus.ARPROT   = arprot_q;
    assign bus.RREADY   = rready_q;
    assign bus.if_valid = if_valid_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_valid = ls_valid_q;
    assign bus.ls_rdata = ls_rdata_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed vector table, corner-case sequences and a randomized run
// against a transaction-level reference model. Honours MEM_ARB_RR_EN when defined.
module tb_mem_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;

    always #5 ACLK = ~ACLK;

    mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    typedef struct packed {
        logic        ifr;
        logic        lsr;
        logic        ary;
        logic        rv;
        logic        rl;
        logic [1:0]  rr;
        logic [63:0] rd;
        logic        e_arv;
        logic        e_rrdy;
        logic [2:0]  e_prot;
        logic        e_ifv;
        logic        e_lsv;
        logic        e_err;
        logic [31:0] e_addr;
        logic [63:0] e_data;
    } vec_t;

    typedef struct packed {
        logic        rv;
        logic        rl;
        logic [1:0]  rr;
        logic [63:0] rd;
    } beat_t;

    typedef enum {M_IDLE, M_AR, M_R, M_DONE} mphase_t;

    localparam logic [63:0] D_FETCH = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D_LOADA = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] D_FETB  = 64'h0BAD_F00D_CAFE_0001;
    localparam logic [63:0] D_JUNK  = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [63:0] D_B4    = 64'h4444_4444_0000_0004;

    int checks = 0;
    int failures = 0;

    vec_t  tbl [13];
    beat_t burst [8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic lsr, input logic ary,
                                 input logic rv, input logic rl, input logic [1:0] rr,
                                 input logic [63:0] rd);
        bus.if_req  = ifr;
        bus.ls_req  = lsr;
        bus.ARREADY = ary;
        bus.RVALID  = rv;
        bus.RLAST   = rl;
        bus.RRESP   = rr;
        bus.RDATA   = rd;
    endtask

    task automatic step();
        @(negedge ACLK);
    endtask

    task automatic doReset();
        ARESETn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        step();
        checkOutput("reset_arvalid", bus.ARVALID, 64'd0);
        checkOutput("reset_rready", bus.RREADY, 64'd0);
        checkOutput("reset_araddr", bus.ARADDR, 64'd0);
        checkOutput("reset_arprot", bus.ARPROT, 64'd0);
        checkOutput("reset_if_valid", bus.if_valid, 64'd0);
        checkOutput("reset_ls_valid", bus.ls_valid, 64'd0);
        checkOutput("reset_err", bus.err, 64'd0);
        checkOutput("reset_if_rdata", bus.if_rdata, 64'd0);
        checkOutput("reset_ls_rdata", bus.ls_rdata, 64'd0);
        ARESETn = 1'b1;
    endtask

    // Reference model: tracks one outstanding transaction as a sequence of protocol phases.
    task automatic runRandom(input int cycles);
        mphase_t     mp;
        logic        who_ls, drop, deliver, errany, last_ls;
        logic [31:0] maddr;
        logic [63:0] held_if, held_ls;
        logic        p_ifr, p_lsr, p_ary, p_rv, p_rl;
        logic [1:0]  p_rr;
        logic [63:0] p_rd;
        logic [31:0] p_ifa, p_lsa;
        logic        if_act, ls_act, e_ifv, e_lsv, req_now;
        logic [31:0] if_a, ls_a;

        doReset();
        mp = M_IDLE;
        who_ls = 1'b0; drop = 1'b0; deliver = 1'b0; errany = 1'b0; last_ls = 1'b0;
        maddr = '0; held_if = '0; held_ls = '0;
        p_ifr = 1'b0; p_lsr = 1'b0; p_ary = 1'b0; p_rv = 1'b0; p_rl = 1'b0; p_rr = 2'b00; p_rd = '0;
        p_ifa = '0; p_lsa = '0; if_act = 1'b0; ls_act = 1'b0; if_a = '0; ls_a = '0;
        bus.if_addr = '0;
        bus.ls_addr = '0;

        for (int c = 0; c < cycles; c++) begin
            step();
            req_now = who_ls ? p_lsr : p_ifr;
            case (mp)
                M_IDLE: begin
                    if (p_ifr || p_lsr) begin
`ifdef MEM_ARB_RR_EN
                        who_ls = (p_ifr && p_lsr) ? !last_ls : p_lsr;
                        last_ls = who_ls;
`else
                        who_ls = p_lsr;
`endif
                        maddr = who_ls ? p_lsa : p_ifa;
                        drop = 1'b0; errany = 1'b0; deliver = 1'b0;
                        mp = M_AR;
                    end
                end
                M_AR: begin
                    if (!req_now) drop = 1'b1;
                    if (p_ary) mp = M_R;
                end
                M_R: begin
                    if (!req_now) drop = 1'b1;
                    if (p_rv) begin
                        if (p_rr[1]) errany = 1'b1;
                        if (p_rl) begin
                            deliver = !drop;
                            mp = M_DONE;
                            if (deliver) begin
                                if (who_ls) held_ls = p_rd;
                                else held_if = p_rd;
                            end
                        end
                    end
                end
                default: mp = M_IDLE;
            endcase

            e_ifv = (mp == M_DONE) && deliver && !who_ls;
            e_lsv = (mp == M_DONE) && deliver && who_ls;
            checkOutput($sformatf("rnd_arvalid@%0d", c), bus.ARVALID, 64'(mp == M_AR));
            if (mp == M_AR) begin
                checkOutput($sformatf("rnd_araddr@%0d", c), bus.ARADDR, 64'(maddr));
                checkOutput($sformatf("rnd_arprot@%0d", c), bus.ARPROT, who_ls ? 64'd0 : 64'd4);
            end
            checkOutput($sformatf("rnd_rready@%0d", c), bus.RREADY, 64'(mp == M_R));
            checkOutput($sformatf("rnd_if_valid@%0d", c), bus.if_valid, 64'(e_ifv));
            checkOutput($sformatf("rnd_ls_valid@%0d", c), bus.ls_valid, 64'(e_lsv));
            checkOutput($sformatf("rnd_err@%0d", c), bus.err, 64'((mp == M_DONE) && deliver && errany));
            checkOutput($sformatf("rnd_if_rdata@%0d", c), bus.if_rdata, held_if);
            checkOutput($sformatf("rnd_ls_rdata@%0d", c), bus.ls_rdata, held_ls);

            // Requesters mostly hold req until served, occasionally give up early.
            if (e_ifv) if_act = 1'b0;
            else if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1;
                if_a = $urandom & 32'hFFFF_FFF8;
            end else if (if_act && $urandom_range(0, 39) == 0) if_act = 1'b0;
            if (e_lsv) ls_act = 1'b0;
            else if (!ls_act && $urandom_range(0, 2) == 0) begin
                ls_act = 1'b1;
                ls_a = $urandom & 32'hFFFF_FFF8;
            end else if (ls_act && $urandom_range(0, 39) == 0) ls_act = 1'b0;

            p_ifr = if_act;
            p_lsr = ls_act;
            p_ary = 1'($urandom_range(0, 1));
            p_rv  = ($urandom_range(0, 2) != 0);
            p_rl  = ($urandom_range(0, 4) == 0);
            p_rr  = 2'($urandom_range(0, 3));
            p_rd  = {$urandom, $urandom};
            p_ifa = if_a;
            p_lsa = ls_a;
            bus.if_addr = if_a;
            bus.ls_addr = ls_a;
            applyStimulus(p_ifr, p_lsr, p_ary, p_rv, p_rl, p_rr, p_rd);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    endtask

    initial begin
        logic [2:0] exp_prot2;
        logic       exp_ls2;

        //           ifr   lsr   ary   rv    rl    rr     rd        arv   rrdy  prot    ifv   lsv   err   addr            data
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0,    1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 64'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, D_FETCH,  1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,         D_FETCH};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0,    1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_1000, 64'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, D_LOADA,  1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0,         D_LOADA};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0,    1'b1, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 64'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, D_JUNK,   1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, D_FETB,   1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,         D_FETB};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, D_JUNK,   1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, D_JUNK,   1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0,         64'h0};

        burst[0] = '{1'b1, 1'b0, 2'b00, 64'h1111_1111_0000_0001};
        burst[1] = '{1'b0, 1'b0, 2'b00, D_JUNK};
        burst[2] = '{1'b1, 1'b0, 2'b10, 64'h2222_2222_0000_0002};
        burst[3] = '{1'b0, 1'b1, 2'b10, D_JUNK};
        burst[4] = '{1'b0, 1'b0, 2'b00, D_JUNK};
        burst[5] = '{1'b1, 1'b0, 2'b00, 64'h3333_3333_0000_0003};
        burst[6] = '{1'b0, 1'b1, 2'b00, D_JUNK};
        burst[7] = '{1'b1, 1'b1, 2'b00, D_B4};

        bus.if_addr = 32'h8000_0000;
        bus.ls_addr = 32'h8000_1000;
        doReset();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].ifr, tbl[i].lsr, tbl[i].ary, tbl[i].rv, tbl[i].rl, tbl[i].rr, tbl[i].rd);
            step();
            checkOutput($sformatf("vec%0d_arvalid", i), bus.ARVALID, 64'(tbl[i].e_arv));
            checkOutput($sformatf("vec%0d_rready", i), bus.RREADY, 64'(tbl[i].e_rrdy));
            checkOutput($sformatf("vec%0d_if_valid", i), bus.if_valid, 64'(tbl[i].e_ifv));
            checkOutput($sformatf("vec%0d_ls_valid", i), bus.ls_valid, 64'(tbl[i].e_lsv));
            checkOutput($sformatf("vec%0d_err", i), bus.err, 64'(tbl[i].e_err));
            if (tbl[i].e_arv) begin
                checkOutput($sformatf("vec%0d_araddr", i), bus.ARADDR, 64'(tbl[i].e_addr));
                checkOutput($sformatf("vec%0d_arprot", i), bus.ARPROT, 64'(tbl[i].e_prot));
            end
            if (tbl[i].e_ifv) checkOutput($sformatf("vec%0d_if_rdata", i), bus.if_rdata, tbl[i].e_data);
            if (tbl[i].e_lsv) checkOutput($sformatf("vec%0d_ls_rdata", i), bus.ls_rdata, tbl[i].e_data);
        end

        // ARREADY stall: address must not follow a changing ls_addr once granted.
        bus.ls_addr = 32'h8000_2000;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("stall_arvalid", bus.ARVALID, 64'd1);
        checkOutput("stall_araddr", bus.ARADDR, 64'h8000_2000);
        checkOutput("stall_arprot", bus.ARPROT, 64'd0);
        bus.ls_addr = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, D_JUNK);
            step();
            checkOutput($sformatf("stall%0d_arvalid", i), bus.ARVALID, 64'd1);
            checkOutput($sformatf("stall%0d_araddr", i), bus.ARADDR, 64'h8000_2000);
            checkOutput($sformatf("stall%0d_rready", i), bus.RREADY, 64'd0);
            checkOutput($sformatf("stall%0d_ls_valid", i), bus.ls_valid, 64'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("stall_done_arvalid", bus.ARVALID, 64'd0);
        checkOutput("stall_done_rready", bus.RREADY, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'hFEED_0000_0000_0042);
        step();
        checkOutput("stall_ls_valid", bus.ls_valid, 64'd1);
        checkOutput("stall_ls_rdata", bus.ls_rdata, 64'hFEED_0000_0000_0042);
        checkOutput("stall_if_valid", bus.if_valid, 64'd0);
        checkOutput("stall_err", bus.err, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("stall_after_ls_valid", bus.ls_valid, 64'd0);

        // Gapped 4-beat burst with an error response on beat 2.
        bus.ls_addr = 32'h8000_4000;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("burst_arvalid", bus.ARVALID, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("burst_rready", bus.RREADY, 64'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, burst[i].rv, burst[i].rl, burst[i].rr, burst[i].rd);
            step();
            if (i < 7) begin
                checkOutput($sformatf("burst%0d_ls_valid", i), bus.ls_valid, 64'd0);
                checkOutput($sformatf("burst%0d_rready", i), bus.RREADY, 64'd1);
            end else begin
                checkOutput("burst_ls_valid", bus.ls_valid, 64'd1);
                checkOutput("burst_ls_rdata", bus.ls_rdata, D_B4);
                checkOutput("burst_err", bus.err, 64'd1);
                checkOutput("burst_if_valid", bus.if_valid, 64'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("burst_after_err", bus.err, 64'd0);
        checkOutput("burst_after_ls_valid", bus.ls_valid, 64'd0);
        checkOutput("burst_hold_ls_rdata", bus.ls_rdata, D_B4);

        // Fetch withdraws its request mid-transaction: bus completes, response is dropped.
        bus.if_addr = 32'h8000_3000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("drop_arvalid", bus.ARVALID, 64'd1);
        checkOutput("drop_arprot", bus.ARPROT, 64'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("drop_rready", bus.RREADY, 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, D_JUNK);
        step();
        checkOutput("drop_if_valid", bus.if_valid, 64'd0);
        checkOutput("drop_rready_off", bus.RREADY, 64'd0);
        checkOutput("drop_hold_if_rdata", bus.if_rdata, D_FETB);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("drop_idle_arvalid", bus.ARVALID, 64'd0);

        // Reset in the data phase abandons the transaction.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("rst_data_rready", bus.RREADY, 64'd1);
        ARESETn = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("rst_arvalid", bus.ARVALID, 64'd0);
        checkOutput("rst_rready", bus.RREADY, 64'd0);
        checkOutput("rst_if_rdata", bus.if_rdata, 64'd0);
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 64'h77);
            step();
            checkOutput($sformatf("rst_after%0d_if_valid", i), bus.if_valid, 64'd0);
            checkOutput($sformatf("rst_after%0d_rready", i), bus.RREADY, 64'd0);
            checkOutput($sformatf("rst_after%0d_arvalid", i), bus.ARVALID, 64'd0);
        end

        // Two back-to-back conflicts with both requests held.
        doReset();
        bus.if_addr = 32'h8000_0000;
        bus.ls_addr = 32'h8000_1000;
`ifdef MEM_ARB_RR_EN
        exp_prot2 = 3'b100;
        exp_ls2 = 1'b0;
`else
        exp_prot2 = 3'b000;
        exp_ls2 = 1'b1;
`endif
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("conf1_arprot", bus.ARPROT, 64'd0);
        checkOutput("conf1_araddr", bus.ARADDR, 64'h8000_1000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'hC1C1_C1C1_C1C1_C1C1);
        step();
        checkOutput("conf1_ls_valid", bus.ls_valid, 64'd1);
        checkOutput("conf1_if_valid", bus.if_valid, 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("conf_gap_arvalid", bus.ARVALID, 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        checkOutput("conf2_arprot", bus.ARPROT, 64'(exp_prot2));
        checkOutput("conf2_araddr", bus.ARADDR, exp_ls2 ? 64'h8000_1000 : 64'h8000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'hC2C2_C2C2_C2C2_C2C2);
        step();
        checkOutput("conf2_ls_valid", bus.ls_valid, 64'(exp_ls2));
        checkOutput("conf2_if_valid", bus.if_valid, 64'(!exp_ls2));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
        step();

        runRandom(2500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
